// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - multi-digit BCD time counter with prescaler, up/down, load and wrap pulse; optional COUNTER_SAT_EN
module bcd_time_counter #(
  parameter int CLK_DIV  = 10,
  parameter int DIGITS   = 4,
  parameter int TENS_MOD = 6
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   num,
  output logic                  tick,
  output logic                  wrap
);

  localparam int PW = ($clog2(CLK_DIV) < 1) ? 1 : $clog2(CLK_DIV);
  localparam logic [PW-1:0] P_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0]         p;
  logic [4*DIGITS-1:0]   up_num;
  logic [4*DIGITS-1:0]   dn_num;
  logic [4*DIGITS-1:0]   ld_num;
  logic [4*DIGITS-1:0]   step_num;
  logic                  carry;
  logic                  borrow;
  logic                  step_wrap;

  // Largest legal value of digit i: odd digits are tens, even digits are units
  function automatic logic [3:0] dig_max(input int i);
    return (i % 2 == 1) ? 4'(TENS_MOD - 1) : 4'd9;
  endfunction

  // Ripple increment/decrement across the chain; a carry/borrow out of the top digit means the chain wrapped
  always_comb begin
    up_num = num;
    dn_num = num;
    ld_num = load_val;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (num[4*i +: 4] >= dig_max(i)) begin
          up_num[4*i +: 4] = 4'd0;
        end else begin
          up_num[4*i +: 4] = num[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (num[4*i +: 4] == 4'd0) begin
          dn_num[4*i +: 4] = dig_max(i);
        end else begin
          dn_num[4*i +: 4] = num[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      if (load_val[4*i +: 4] > dig_max(i)) begin
        ld_num[4*i +: 4] = dig_max(i);
      end
    end
    step_wrap = up_dn ? carry : borrow;
`ifdef COUNTER_SAT_EN
    if (step_wrap) begin
      step_num = num;
    end else begin
      step_num = up_dn ? up_num : dn_num;
    end
`else
    step_num = up_dn ? up_num : dn_num;
`endif
  end

  // Prescaler, digit register and registered pulses; reset beats load beats step
  always_ff @(posedge clk) begin
    if (res) begin
      p    <= '0;
      num  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      p    <= '0;
      num  <= ld_num;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (en) begin
      if (p == P_MAX) begin
        p    <= '0;
        num  <= step_num;
        tick <= 1'b1;
        wrap <= step_wrap;
      end else begin
        p    <= p + PW'(1);
        tick <= 1'b0;
        wrap <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - self-checking bench for bcd_time_counter (default and CLK_DIV=1/DIGITS=2 instances)
module tb_bcd_time_counter;

  localparam int TM = 6;

  logic        clk = 1'b0;
  logic        res, en, up_dn, load;
  logic [15:0] load_val;
  logic [15:0] num_a;
  logic [7:0]  num_b;
  logic        tick_a, wrap_a, tick_b, wrap_b;

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] m_num  [2];
  int          m_p    [2];
  logic        m_tick [2];
  logic        m_wrap [2];
  int          nd     [2] = '{4, 2};
  int          div    [2] = '{10, 1};

  always #5 clk = ~clk;

  bcd_time_counter dut_a (
    .clk(clk), .res(res), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .num(num_a), .tick(tick_a), .wrap(wrap_a)
  );

  bcd_time_counter #(.CLK_DIV(1), .DIGITS(2), .TENS_MOD(TM)) dut_b (
    .clk(clk), .res(res), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[7:0]), .num(num_b), .tick(tick_b), .wrap(wrap_b)
  );

  function automatic int modulus(int i);
    return (i % 2 == 1) ? TM : 10;
  endfunction

  function automatic int total(int n);
    int t = 1;
    for (int i = 0; i < n; i++) t = t * modulus(i);
    return t;
  endfunction

  // Mixed-radix BCD -> plain integer count
  function automatic int to_int(logic [31:0] b, int n);
    int v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * modulus(i) + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [31:0] from_int(int v, int n);
    logic [31:0] b = '0;
    for (int i = 0; i < n; i++) begin
      b[4*i +: 4] = 4'(v % modulus(i));
      v = v / modulus(i);
    end
    return b;
  endfunction

  function automatic logic [31:0] clamp(logic [15:0] lv, int n);
    logic [31:0] b = '0;
    int d;
    for (int i = 0; i < n; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > modulus(i) - 1) d = modulus(i) - 1;
      b[4*i +: 4] = 4'(d);
    end
    return b;
  endfunction

  task automatic model_edge(int k);
    int v, tot;
    if (res) begin
      m_num[k] = '0; m_p[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end else if (load) begin
      m_num[k] = clamp(load_val, nd[k]); m_p[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end else if (en) begin
      if (m_p[k] == div[k] - 1) begin
        m_p[k] = 0;
        m_tick[k] = 1;
        m_wrap[k] = 0;
        v = to_int(m_num[k], nd[k]);
        tot = total(nd[k]);
        if (up_dn) begin
          if (v == tot - 1) begin
            m_wrap[k] = 1;
`ifndef COUNTER_SAT_EN
            v = 0;
`endif
          end else v = v + 1;
        end else begin
          if (v == 0) begin
            m_wrap[k] = 1;
`ifndef COUNTER_SAT_EN
            v = tot - 1;
`endif
          end else v = v - 1;
        end
        m_num[k] = from_int(v, nd[k]);
      end else begin
        m_p[k] = m_p[k] + 1; m_tick[k] = 0; m_wrap[k] = 0;
      end
    end else begin
      m_tick[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge(0);
    model_edge(1);
    chk("num_a",  32'(num_a),  m_num[0]);
    chk("tick_a", 32'(tick_a), 32'(m_tick[0]));
    chk("wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
    chk("num_b",  32'(num_b),  m_num[1]);
    chk("tick_b", 32'(tick_b), 32'(m_tick[1]));
    chk("wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
  endtask

  task automatic do_load(logic [15:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    for (int k = 0; k < 2; k++) begin
      m_num[k] = '0; m_p[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end
    cyc(); cyc();
    chk("reset_num", 32'(num_a), 32'h0000);

    // first step on the 10th enabled edge
    res = 1'b0; en = 1'b1;
    repeat (9) cyc();
    chk("first_pre", 32'(tick_a), 32'h0);
    cyc();
    chk("first_num", 32'(num_a), 32'h0001);
    chk("first_tick", 32'(tick_a), 32'h1);
    repeat (10) cyc();
    chk("second_num", 32'(num_a), 32'h0002);

    // carry across digits
    do_load(16'h0959);
    repeat (10) cyc();
    chk("carry_num", 32'(num_a), 32'h1000);
    chk("carry_wrap", 32'(wrap_a), 32'h0);

    // load on the same edge a step is due
    for (int i = 0; i < 20 && m_p[0] != 9; i++) cyc();
    do_load(16'h1234);
    chk("ldstep_num", 32'(num_a), 32'h1234);
    chk("ldstep_tick", 32'(tick_a), 32'h0);

    // full wrap up
    do_load(16'h5959);
    repeat (10) cyc();
`ifdef COUNTER_SAT_EN
    chk("wrapup_num", 32'(num_a), 32'h5959);
`else
    chk("wrapup_num", 32'(num_a), 32'h0000);
`endif
    chk("wrapup_wrap", 32'(wrap_a), 32'h1);
    cyc();
    chk("wrapup_wrap_clr", 32'(wrap_a), 32'h0);

    // down borrow and down wrap
    up_dn = 1'b0;
    do_load(16'h1000);
    repeat (10) cyc();
    chk("borrow_num", 32'(num_a), 32'h0959);
    do_load(16'h0000);
    repeat (10) cyc();
`ifdef COUNTER_SAT_EN
    chk("wrapdn_num", 32'(num_a), 32'h0000);
`else
    chk("wrapdn_num", 32'(num_a), 32'h5959);
`endif
    chk("wrapdn_wrap", 32'(wrap_a), 32'h1);

    // enable freeze
    up_dn = 1'b1; res = 1'b1;
    cyc();
    res = 1'b0; en = 1'b1;
    repeat (4) cyc();
    en = 1'b0;
    repeat (20) cyc();
    chk("freeze_num", 32'(num_a), 32'h0000);
    en = 1'b1;
    repeat (5) cyc();
    chk("refreeze_pre", 32'(num_a), 32'h0000);
    cyc();
    chk("refreeze_num", 32'(num_a), 32'h0001);

    // clamp
    do_load(16'h7A0F);
    chk("clamp_num", 32'(num_a), 32'h5909);

    // reset in mid-prescale
    for (int i = 0; i < 20 && m_p[0] != 7; i++) cyc();
    res = 1'b1;
    cyc();
    chk("midres_num", 32'(num_a), 32'h0000);
    res = 1'b0;
    repeat (9) cyc();
    chk("midres_pre", 32'(num_a), 32'h0000);
    cyc();
    chk("midres_step", 32'(num_a), 32'h0001);

    // two-digit, divide-by-one instance near its top
    do_load(16'h0058);
    cyc();
    chk("b_59", 32'(num_b), 32'h59);
    cyc();
`ifdef COUNTER_SAT_EN
    chk("b_wrap_num", 32'(num_b), 32'h59);
`else
    chk("b_wrap_num", 32'(num_b), 32'h00);
`endif
    chk("b_wrap", 32'(wrap_b), 32'h1);

    // randomized operation against the model
    for (int i = 0; i < 1500; i++) begin
      res  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: load_val = 16'h5959;
        1: load_val = 16'h0000;
        default: load_val = 16'($urandom);
      endcase
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) up_dn = ~up_dn;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
